// File: rtl/mem_port_arbiter.sv
// Arbitrates one external memory port between fetch and memacc, one transaction in flight.
// Optional ARB_PERF_CNT_EN adds conflict and fetch-wait performance counters.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [2:0]  FETCH_WIDTH  = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_width,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_width,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_conflict_cnt,
  output logic [31:0] perf_fetch_wait_cnt
`endif
);

  localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StreakW-1:0] Limit = StreakW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;
  typedef enum logic {OwnData, OwnFetch} owner_e;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               drop_q, drop_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [2:0]         width_q, width_d;
  logic [31:0]        d_rdata_q, d_rdata_d, if_rdata_q, if_rdata_d;
  logic               data_win;

  // Data wins unless fetch has been starved for STARVE_LIMIT consecutive data grants.
  assign data_win = d_req && !(if_req && (streak_q == Limit));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    drop_d     = drop_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    width_d    = width_q;
    d_rdata_d  = d_rdata_q;
    if_rdata_d = if_rdata_q;
    d_ready    = 1'b0;
    if_ready   = 1'b0;
    mem_req    = 1'b0;
    d_rvalid   = 1'b0;
    if_rvalid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (data_win) begin
          d_ready = 1'b1;
          owner_d = OwnData;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          width_d = d_width;
          state_d = StReq;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != Limit) begin
            streak_d = streak_q + StreakW'(1);
          end
        end else if (if_req) begin
          if_ready = 1'b1;
          owner_d  = OwnFetch;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          width_d  = FETCH_WIDTH;
          streak_d = '0;
          state_d  = StReq;
        end
      end
      StReq: begin
        mem_req = 1'b1;
        if (owner_q == OwnFetch && if_flush) drop_d = 1'b1;
        if (mem_gnt) state_d = StWait;
      end
      StWait: begin
        if (owner_q == OwnFetch && if_flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          state_d = StResp;
          if (owner_q == OwnData) begin
            d_rdata_d = mem_rdata;
          end else if (!drop_q && !if_flush) begin
            if_rdata_d = mem_rdata;
          end
        end
      end
      StResp: begin
        drop_d  = 1'b0;
        state_d = StIdle;
        if (owner_q == OwnData) begin
          d_rvalid = 1'b1;
        end else begin
          // A flush landing in the response cycle itself still suppresses the pulse.
          if_rvalid = !drop_q && !if_flush;
        end
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      d_ready   = 1'b0;
      if_ready  = 1'b0;
      mem_req   = 1'b0;
      d_rvalid  = 1'b0;
      if_rvalid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= OwnData;
      streak_q   <= '0;
      drop_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      width_q    <= '0;
      d_rdata_q  <= '0;
      if_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      drop_q     <= drop_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      width_q    <= width_d;
      d_rdata_q  <= d_rdata_d;
      if_rdata_q <= if_rdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_width = width_q;
  assign d_rdata   = d_rdata_q;
  assign if_rdata  = if_rdata_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_q, fetch_wait_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q   <= '0;
      fetch_wait_q <= '0;
    end else begin
      if (state_q == StIdle && d_req && if_req) conflict_q <= conflict_q + 32'd1;
      if (if_req && !if_ready) fetch_wait_q <= fetch_wait_q + 32'd1;
    end
  end

  assign perf_conflict_cnt   = conflict_q;
  assign perf_fetch_wait_cnt = fetch_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_width;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_width;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_cnt, perf_fetch_wait_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4), .FETCH_WIDTH(3'b010)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_ready   (if_ready),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_we       (d_we),
    .d_wdata    (d_wdata),
    .d_width    (d_width),
    .d_ready    (d_ready),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_width  (mem_width),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_conflict_cnt   (perf_conflict_cnt),
    .perf_fetch_wait_cnt (perf_fetch_wait_cnt)
`endif
  );

  typedef struct {
    logic        dq;
    logic        iq;
    logic        we;
    logic [2:0]  width;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [31:0] iaddr;
    int          delay;
    logic [31:0] rdata;
    logic        flush;
    logic        e_dready;
    logic        e_iready;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [2:0]  e_width;
    logic        e_drv;
    logic        e_irv;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    d_req = v.dq; if_req = v.iq; d_we = v.we; d_width = v.width;
    d_addr = v.daddr; d_wdata = v.wdata; if_addr = v.iaddr;
    #1;
    chk($sformatf("v%0d.d_ready", i), 32'(d_ready), 32'(v.e_dready));
    chk($sformatf("v%0d.if_ready", i), 32'(if_ready), 32'(v.e_iready));
    step();
    d_req = 1'b0; if_req = 1'b0;
    mem_gnt = (v.delay == 0);
    #1;
    chk($sformatf("v%0d.mem_req", i), 32'(mem_req), 32'd1);
    chk($sformatf("v%0d.mem_addr", i), mem_addr, v.e_addr);
    chk($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(v.e_we));
    chk($sformatf("v%0d.mem_wdata", i), mem_wdata, v.e_wdata);
    chk($sformatf("v%0d.mem_width", i), 32'(mem_width), 32'(v.e_width));
    for (int k = 0; k < v.delay; k++) begin
      step();
      chk($sformatf("v%0d.stall%0d.mem_req", i, k), 32'(mem_req), 32'd1);
      chk($sformatf("v%0d.stall%0d.mem_wdata", i, k), mem_wdata, v.e_wdata);
      chk($sformatf("v%0d.stall%0d.mem_we", i, k), 32'(mem_we), 32'(v.e_we));
      chk($sformatf("v%0d.stall%0d.mem_width", i, k), 32'(mem_width), 32'(v.e_width));
      if (k == v.delay - 1) mem_gnt = 1'b1;
    end
    step();
    mem_gnt = 1'b0;
    chk($sformatf("v%0d.wait.mem_req", i), 32'(mem_req), 32'd0);
    if_flush = v.flush; mem_rvalid = 1'b1; mem_rdata = v.rdata;
    step();
    if_flush = 1'b0; mem_rvalid = 1'b0;
    chk($sformatf("v%0d.d_rvalid", i), 32'(d_rvalid), 32'(v.e_drv));
    chk($sformatf("v%0d.if_rvalid", i), 32'(if_rvalid), 32'(v.e_irv));
    if (v.e_drv) chk($sformatf("v%0d.d_rdata", i), d_rdata, v.rdata);
    if (v.e_irv) chk($sformatf("v%0d.if_rdata", i), if_rdata, v.rdata);
    step();
    chk($sformatf("v%0d.idle.rvalid", i), 32'({d_rvalid, if_rvalid}), 32'd0);
    chk($sformatf("v%0d.idle.mem_req", i), 32'(mem_req), 32'd0);
  endtask

  initial begin
    logic [9:0]  order;
    logic        fslot;
    logic [31:0] conflict_start;
    conflict_start = '0;

    // dq iq we width daddr wdata iaddr delay rdata flush | dready iready addr we wdata width drv irv
    vecs[0] = '{1, 0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 32'hDEADBEEF, 0,
                1, 0, 32'h100, 0, 32'h0, 3'b010, 1, 0};
    vecs[1] = '{1, 0, 1, 3'b000, 32'h200, 32'h12345678, 32'h0, 3, 32'h0, 0,
                1, 0, 32'h200, 1, 32'h12345678, 3'b000, 1, 0};
    vecs[2] = '{0, 1, 1, 3'b000, 32'h0, 32'hFFFFFFFF, 32'h1000, 1, 32'h00000013, 0,
                0, 1, 32'h1000, 0, 32'h0, 3'b010, 0, 1};
    vecs[3] = '{1, 1, 0, 3'b101, 32'h300, 32'h0, 32'h2000, 0, 32'hCAFEF00D, 0,
                1, 0, 32'h300, 0, 32'h0, 3'b101, 1, 0};
    vecs[4] = '{0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h2004, 0, 32'hBAD0BAD0, 1,
                0, 1, 32'h2004, 0, 32'h0, 3'b010, 0, 0};
    vecs[5] = '{0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h2008, 0, 32'h11223344, 0,
                0, 1, 32'h2008, 0, 32'h0, 3'b010, 0, 1};

    reset = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b1; d_addr = 32'h40; d_we = 1'b0; d_wdata = '0; d_width = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    chk("reset.d_ready", 32'(d_ready), 32'd0);
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.rvalids", 32'({d_rvalid, if_rvalid}), 32'd0);
    chk("reset.rdata", d_rdata | if_rdata, 32'd0);
    reset = 1'b0; d_req = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset while waiting for the response; the late rvalid must be ignored.
    if_req = 1'b1; if_addr = 32'h5000;
    step();
    if_req = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_wait.mem_req", 32'(mem_req), 32'd0);
    chk("rst_wait.mem_addr", mem_addr, 32'd0);
    chk("rst_wait.if_rdata", if_rdata, 32'd0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    step();
    mem_rvalid = 1'b0;
    chk("rst_wait.rvalids", 32'({d_rvalid, if_rvalid}), 32'd0);
    chk("rst_wait.if_rdata_late", if_rdata, 32'd0);
    step();
    chk("rst_wait.rvalids2", 32'({d_rvalid, if_rvalid}), 32'd0);
    chk("rst_wait.mem_req2", 32'(mem_req), 32'd0);

    // Both requesters hold high: expect D,D,D,D,F,D,D,D,D,F.
    order = 10'b10_0001_0000;
    d_addr = 32'h400; d_we = 1'b0; d_width = 3'b010; if_addr = 32'h3000;
`ifdef ARB_PERF_CNT_EN
    conflict_start = perf_conflict_cnt;
`endif
    for (int s = 0; s < 10; s++) begin
      d_req = 1'b1; if_req = 1'b1;
      #1;
      fslot = order[s];
      chk($sformatf("starve%0d.d_ready", s), 32'(d_ready), 32'(!fslot));
      chk($sformatf("starve%0d.if_ready", s), 32'(if_ready), 32'(fslot));
      step();
      chk($sformatf("starve%0d.mem_addr", s), mem_addr, fslot ? 32'h3000 : 32'h400);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'(s);
      step();
      mem_rvalid = 1'b0;
      chk($sformatf("starve%0d.if_rvalid", s), 32'(if_rvalid), 32'(fslot));
      chk($sformatf("starve%0d.d_rvalid", s), 32'(d_rvalid), 32'(!fslot));
      chk($sformatf("starve%0d.resp_ready", s), 32'({d_ready, if_ready}), 32'd0);
      step();
    end
    d_req = 1'b0; if_req = 1'b0;
`ifdef ARB_PERF_CNT_EN
    chk("perf.conflict", perf_conflict_cnt - conflict_start, 32'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
